mem_arbiter: RTL
================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 16, which sets the byte-address width of both ports and the memory.
REQ-002 SHALL have port clk, input, 1 bit: single system clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset; one clock, asynchronous, active-low.
REQ-004 SHALL have port i_req, input, 1 bit: instruction-fetch read request, held until i_ack.
REQ-005 SHALL have port i_addr, input, ADDR_WIDTH bits: fetch byte address.
REQ-006 SHALL have port i_ack, output, 1 bit: fetch completion, one-cycle pulse.
REQ-007 SHALL have port i_rdata, output, 16 bits: fetch data, valid while i_ack=1.
REQ-008 SHALL have port d_req, input, 1 bit: data-port request, held until d_ack.
REQ-009 SHALL have port d_wr, input, 1 bit: 1=write, 0=read.
REQ-010 SHALL have port d_addr, input, ADDR_WIDTH bits: data byte address.
REQ-011 SHALL have port d_wdata, input, 16 bits: write data.
REQ-012 SHALL have port d_ack, output, 1 bit: data completion, one-cycle pulse.
REQ-013 SHALL have port d_rdata, output, 16 bits: read data, valid while d_ack=1 and d_wr=0.
REQ-014 SHALL have port d_err, output, 1 bit: misaligned access, valid with d_ack.
REQ-015 SHALL have memory-side ports mem_enable (out, 1), mem_wr (out, 1), mem_addr (out, ADDR_WIDTH), mem_wdata (out, 16) and mem_rdata (in, 16); these connect to the single-ported, combinational-read, rising-edge-write 16-bit memory.

Function
REQ-016 SHALL implement FSM IDLE -> ACC -> IDLE; ACC lasts exactly one cycle.
REQ-017 In IDLE with any request, SHALL arbitrate, latch winner id, addr, wr and wdata, and go to ACC at the next edge.
REQ-018 In IDLE with no request, SHALL remain in IDLE with all memory outputs 0.
REQ-019 In ACC, SHALL drive mem_enable=1, mem_addr, mem_wr and mem_wdata from latched values, and assert the winner's ack combinationally.
REQ-020 In ACC, winner's rdata SHALL equal mem_rdata; the loser's rdata and all rdata outside ACC SHALL be 0.
REQ-021 Fetch SHALL always read (mem_wr=0); i_addr[0]=1 SHALL be ignored (forced 0).
REQ-022 Data access with d_addr[0]=1 SHALL take ACC with mem_enable=0, d_ack=1 and d_err=1; the memory SHALL NOT be written.
REQ-023 Latency SHALL be request-to-ack 2 cycles when uncontended; max throughput SHALL be one access per 2 cycles.
REQ-024 Simultaneous i_req and d_req: fixed priority to the data port (see Configuration); the loser SHALL be served in the next IDLE.
REQ-025 Request dropped during ACC: the access SHALL still complete and the ack still pulse; request inputs SHALL be ignored outside IDLE.
REQ-026 mem_enable and mem_wr SHALL never both be driven from a non-ACC state.

Reset
REQ-027 Reset assertion SHALL force IDLE immediately, all outputs 0 and the RR pointer to port 0 (fetch); an in-flight ACC SHALL be aborted with no ack and no write.
REQ-028 SHALL begin arbitration on the first rising edge after deassertion.

Configuration
REQ-029 With MEM_ARB_RR_EN defined, ties SHALL use round-robin: a 1-bit pointer toggles to the non-winner after each granted access.
REQ-030 Without MEM_ARB_RR_EN, ties SHALL use fixed priority with data over fetch, and there SHALL be no pointer flop.

Structure
REQ-031 Shared package mem_arb_pkg SHALL hold the state encoding (IDLE, ACC), port-id constants (PORT_I=0, PORT_D=1) and the 16-bit word width.
REQ-032 SHALL contain one sub-module, mem_arb_pick: combinational 2-way picker (reqs, pointer -> grant id).

Verification
REQ-033 Uncontended read: mem[0x0010]=0xBEEF, i_req with i_addr=0x0010 -> i_ack in cycle 2, i_rdata=0xBEEF, mem_wr=0.
REQ-034 Write then read: d_wr=1, d_addr=0x0020, d_wdata=0x1234 -> d_ack; then d_wr=0 at the same address -> d_rdata=0x1234.
REQ-035 Contention: i_req and d_req both held for 4 cycles -> fixed mode gives D then I; RR mode, with pointer starting at fetch, gives I then D.
REQ-036 Misaligned access: d_addr=0x0021 write -> d_ack=1, d_err=1, mem_enable=0; a subsequent read of 0x0020 returns its previous value.
REQ-037 Reset in ACC: drive rst low during ACC of a write to 0x0030 -> no d_ack, mem[0x0030] unchanged, state IDLE.
REQ-038 Dropped request: deassert d_req during ACC -> d_ack still pulses once, with no second access.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared definitions for the two-port memory arbiter: FSM encoding, port ids, word width.
package mem_arb_pkg;

    localparam int WORD_W = 16;

    localparam logic PORT_I = 1'b0;
    localparam logic PORT_D = 1'b1;

    typedef enum logic {
        IDLE = 1'b0,
        ACC  = 1'b1
    } state_t;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational 2-way picker: single requester wins outright, a tie goes to the port named by ptr_i.
module mem_arb_pick
    import mem_arb_pkg::*;
(
    input  logic fetch_req_i,
    input  logic data_req_i,
    input  logic ptr_i,
    output logic gnt_o
);

    always_comb begin
        gnt_o = PORT_I;
        if (fetch_req_i && data_req_i) begin
            gnt_o = ptr_i;
        end else if (data_req_i) begin
            gnt_o = PORT_D;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates a fetch port and a data port onto one 16-bit memory, one access per two cycles.
// Define MEM_ARB_RR_EN for round-robin tie-breaking; otherwise data wins ties.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_req,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    output logic                  i_ack,
    output logic [WORD_W-1:0]     i_rdata,
    input  logic                  d_req,
    input  logic                  d_wr,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [WORD_W-1:0]     d_wdata,
    output logic                  d_ack,
    output logic [WORD_W-1:0]     d_rdata,
    output logic                  d_err,
    output logic                  mem_enable,
    output logic                  mem_wr,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [WORD_W-1:0]     mem_wdata,
    input  logic [WORD_W-1:0]     mem_rdata
);

    state_t                  state_q, state_d;
    logic                    win_q, wr_q, err_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [WORD_W-1:0]       wdata_q;
    logic                    gnt;
    logic                    ptr;
    logic                    grab;
    logic [ADDR_WIDTH-1:0]   i_addr_al;

    assign grab      = (state_q == IDLE) && (i_req || d_req);
    assign i_addr_al = i_addr & ~ADDR_WIDTH'(1);

`ifdef MEM_ARB_RR_EN
    logic ptr_q;

    // Pointer hands the next tie to whichever port lost this grant.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr_q <= PORT_I;
        end else if (grab) begin
            ptr_q <= ~gnt;
        end
    end

    assign ptr = ptr_q;
`else
    assign ptr = PORT_D;
`endif

    mem_arb_pick u_pick (
        .fetch_req_i (i_req),
        .data_req_i  (d_req),
        .ptr_i       (ptr),
        .gnt_o       (gnt)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            win_q   <= PORT_I;
            wr_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (grab) begin
                win_q <= gnt;
                wr_q  <= (gnt == PORT_D) && d_wr;
                err_q <= (gnt == PORT_D) && d_addr[0];
            end
        end
    end

    // Address and write data need no reset: they are only observed in ACC.
    always_ff @(posedge clk) begin
        if (grab) begin
            addr_q  <= (gnt == PORT_D) ? d_addr : i_addr_al;
            wdata_q <= (gnt == PORT_D) ? d_wdata : '0;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (i_req || d_req) state_d = ACC;
            ACC:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        i_ack      = 1'b0;
        i_rdata    = '0;
        d_ack      = 1'b0;
        d_rdata    = '0;
        d_err      = 1'b0;
        mem_enable = 1'b0;
        mem_wr     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        if (state_q == ACC) begin
            mem_enable = !err_q;
            mem_wr     = wr_q && !err_q;
            mem_addr   = addr_q;
            mem_wdata  = wdata_q;
            if (win_q == PORT_D) begin
                d_ack   = 1'b1;
                d_err   = err_q;
                d_rdata = mem_rdata;
            end else begin
                i_ack   = 1'b1;
                i_rdata = mem_rdata;
            end
        end
    end

endmodule
